// File: rtl/j1_boot_ctrl.sv
// rtl/j1_boot_ctrl.sv - boot/load sequencer: framed byte-stream image loader for the j1 program RAM
module j1_boot_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic              halt_i,
    output logic              core_rst_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic              boot_done_o,
    output logic              boot_err_o
);

    localparam logic [7:0]  SYNC_LOAD = 8'hA5;
    localparam logic [7:0]  SYNC_RUN  = 8'h5A;
    // Largest legal image, compared in 17 bits so N up to 0xFFFF is judged correctly.
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
    localparam int          CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [15:0]        r_len;
    logic [ADDR_W-1:0]  r_word_idx;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_word_buf;
    logic [7:0]         r_csum;
    logic [CNT_W-1:0]   r_idle_cnt;

    logic               r_rx_ready;
    logic               r_core_rst;
    logic               r_boot_done;
    logic               r_boot_err;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [31:0]        r_ram_wdata;

    logic               w_accept;
    logic               w_in_frame;
    logic               w_timeout;
    logic               w_last_word;
    logic [15:0]        w_len_full;
    logic               w_err_set;
    logic               w_err_clr;

    assign w_accept    = rx_valid_i & r_rx_ready;
    assign w_in_frame  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                         (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_timeout   = w_in_frame && !w_accept && (r_idle_cnt == CNT_LAST);
    assign w_last_word = (17'(r_word_idx) == (17'(r_len) - 17'd1));
    assign w_len_full  = {rx_data_i, r_len[7:0]};

    // State register.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus error set/clear requests.
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (rx_data_i == SYNC_LOAD) begin
                        w_state_nxt = S_LEN_LO;
                        w_err_clr   = 1'b1;
                    end else if (rx_data_i == SYNC_RUN) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    w_state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_len_full} > MAX_WORDS) begin
                        w_state_nxt = S_IDLE;
                        w_err_set   = 1'b1;
                    end else if (w_len_full == 16'd0) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3) && w_last_word) begin
                    w_state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (rx_data_i == r_csum) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err_set   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (halt_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A stalled frame is abandoned regardless of where it stopped.
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_err_set   = 1'b1;
        end
    end

    // Status outputs are derived from the next state so they change on the same edge as the state.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_rx_ready  <= 1'b1;
            r_core_rst  <= 1'b1;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            r_rx_ready  <= (w_state_nxt != S_RUN);
            r_core_rst  <= (w_state_nxt != S_RUN);
            r_boot_done <= (w_state_nxt == S_RUN);
            if (w_err_set) begin
                r_boot_err <= 1'b1;
            end else if (w_err_clr) begin
                r_boot_err <= 1'b0;
            end
        end
    end

    // Inter-byte idle counter; only runs while a frame is open.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_idle_cnt <= '0;
        end else if (w_accept || !w_in_frame || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Frame datapath: length capture, byte assembly, checksum and RAM write strobe.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_len       <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_word_buf  <= '0;
            r_csum      <= '0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (rx_data_i == SYNC_LOAD)) begin
                        r_csum <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data_i;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data_i;
                        r_word_idx  <= '0;
                        r_byte_idx  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ rx_data_i;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word_buf[7:0]   <= rx_data_i;
                            2'd1: r_word_buf[15:8]  <= rx_data_i;
                            2'd2: r_word_buf[23:16] <= rx_data_i;
                            default: begin
                                // Fourth byte completes the word: strobe it out next cycle.
                                r_ram_we    <= 1'b1;
                                r_ram_addr  <= r_word_idx;
                                r_ram_wdata <= {rx_data_i, r_word_buf};
                                r_word_idx  <= r_word_idx + 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_ready_o  = r_rx_ready;
    assign core_rst_o  = r_core_rst;
    assign boot_done_o = r_boot_done;
    assign boot_err_o  = r_boot_err;
    assign ram_we_o    = r_ram_we;
    assign ram_addr_o  = r_ram_addr;
    assign ram_wdata_o = r_ram_wdata;

endmodule
